// File: rtl/risc8_mem_responder_if.sv
// Request/response bus between the risc8 core (master) and the memory responder (slave).
interface risc8_mem_responder_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/risc8_mem_responder.sv
// risc8 memory bus target: one request at a time, serviced after WAIT_CYCLES wait states.
// Define RISC8_MEM_ERR_EN to flag addresses >= DEPTH as errors instead of wrapping them.
module risc8_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    risc8_mem_responder_if.slave bus
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       alive_q;

    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;

    logic [7:0] mem [DEPTH];

    logic          req_ready;
    logic          accept;
    logic          service;
    logic          svc_from_bus;
    logic          svc_we;
    logic          svc_err;
    logic [7:0]    svc_addr;
    logic [7:0]    svc_wdata;
    logic [AW-1:0] svc_idx;

    // alive_q keeps req_ready low until the first edge after reset release.
    assign req_ready = alive_q && (state_q == ST_IDLE);

    // With zero wait states the service point coincides with the accept,
    // so the request is taken straight from the bus rather than the latches.
    assign svc_from_bus = (state_q == ST_IDLE);
    assign svc_we       = svc_from_bus ? bus.req_we    : we_q;
    assign svc_addr     = svc_from_bus ? bus.req_addr  : addr_q;
    assign svc_wdata    = svc_from_bus ? bus.req_wdata : wdata_q;
    assign svc_idx      = svc_addr[AW-1:0];

`ifdef RISC8_MEM_ERR_EN
    logic err_q, err_d;

    assign svc_err = ({1'b0, svc_addr} >= 9'(DEPTH));
`else
    logic unused_addr_hi;

    assign svc_err        = 1'b0;
    assign unused_addr_hi = ^(svc_addr >> AW);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        service = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        service = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    service = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (service) begin
            rdata_d = (svc_we || svc_err) ? 8'h00 : mem[svc_idx];
        end
    end

`ifdef RISC8_MEM_ERR_EN
    always_comb begin
        err_d = err_q;
        if (service) begin
            err_d = svc_err;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 8'h00;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            alive_q <= 1'b1;
        end
    end

`ifdef RISC8_MEM_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Memory contents survive reset; only a completed service point changes them.
    always_ff @(posedge clk) begin
        if (service && svc_we && !svc_err) begin
            mem[svc_idx] <= svc_wdata;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
`ifdef RISC8_MEM_ERR_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_risc8_mem_responder.sv
// Bench for risc8_mem_responder: four instances (WAIT 1/0/4, DEPTH 256/16) driven from tables and random traffic.
module tb_risc8_mem_responder;
    localparam int NI = 4;

`ifdef RISC8_MEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rstn_a;
    logic [NI-1:0] vld_a;
    logic [NI-1:0] we_a;
    logic [NI-1:0] rrdy_a;
    logic [7:0]    addr_a [NI];
    logic [7:0]    wdat_a [NI];
    logic [NI-1:0] qrdy_a;
    logic [NI-1:0] rspv_a;
    logic [NI-1:0] err_a;
    logic [7:0]    rdat_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        risc8_mem_responder_if bus ();

        assign bus.req_valid = vld_a[g];
        assign bus.req_we    = we_a[g];
        assign bus.req_addr  = addr_a[g];
        assign bus.req_wdata = wdat_a[g];
        assign bus.rsp_ready = rrdy_a[g];
        assign qrdy_a[g]     = bus.req_ready;
        assign rspv_a[g]     = bus.rsp_valid;
        assign err_a[g]      = bus.rsp_err;
        assign rdat_a[g]     = bus.rsp_rdata;

        risc8_mem_responder #(
            .DEPTH       ((g == 3) ? 16 : 256),
            .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 4 : 1)
        ) u_dut (
            .clk     (clk),
            .reset_n (rstn_a[g]),
            .bus     (bus)
        );
    end

    function automatic int wc_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        return (i == 3) ? 16 : 256;
    endfunction

    function automatic bit oor(input int i, input logic [7:0] a);
        return ERR && (int'(a) >= dep_of(i));
    endfunction

    // Reference memory per instance: -1 marks a never-written word.
    int mdl [NI][256];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i, input string name);
        int t;
        t = 0;
        while (!qrdy_a[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!qrdy_a[i]) check(name, 32'(qrdy_a[i]), 32'd1);
    endtask

    // One complete transaction; hold > 0 stalls the response and offers a
    // spurious write of 8'hEE that must be ignored.
    task automatic do_txn(input int i, input bit we, input logic [7:0] a, input logic [7:0] wd,
                          input int hold, output logic [7:0] rd, output logic er);
        int         lat;
        int         idx;
        bit         exp_err;
        bit         known;
        logic [7:0] exp_rd;

        exp_err = oor(i, a);
        idx     = int'(a) % dep_of(i);
        known   = 1'b1;
        exp_rd  = 8'h00;
        if (!we && !exp_err) begin
            known  = (mdl[i][idx] >= 0);
            exp_rd = 8'(mdl[i][idx]);
        end
        rd = 8'h00;
        er = 1'b0;

        @(negedge clk);
        vld_a[i]  = 1'b1;
        we_a[i]   = we;
        addr_a[i] = a;
        wdat_a[i] = wd;
        rrdy_a[i] = (hold == 0);
        wait_ready(i, $sformatf("accept_timeout i%0d", i));
        if (!qrdy_a[i]) begin
            vld_a[i]  = 1'b0;
            rrdy_a[i] = 1'b1;
            return;
        end

        @(negedge clk);
        vld_a[i] = 1'b0;
        lat = 1;
        while (!rspv_a[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency i%0d a%0h", i, a), 32'(lat), 32'(wc_of(i) + 1));
        if (!rspv_a[i]) begin
            rrdy_a[i] = 1'b1;
            return;
        end
        rd = rdat_a[i];
        er = err_a[i];

        if (hold > 0) begin
            vld_a[i]  = 1'b1;
            we_a[i]   = 1'b1;
            wdat_a[i] = 8'hEE;
            repeat (hold) begin
                @(negedge clk);
                check($sformatf("bp_valid i%0d", i), 32'(rspv_a[i]), 32'd1);
                check($sformatf("bp_rdata i%0d", i), 32'(rdat_a[i]), 32'(rd));
                check($sformatf("bp_err i%0d", i), 32'(err_a[i]), 32'(er));
                check($sformatf("bp_req_ready i%0d", i), 32'(qrdy_a[i]), 32'd0);
            end
            vld_a[i]  = 1'b0;
            rrdy_a[i] = 1'b1;
        end

        @(negedge clk);
        check($sformatf("rsp_valid_drop i%0d", i), 32'(rspv_a[i]), 32'd0);
        check($sformatf("req_ready_back i%0d", i), 32'(qrdy_a[i]), 32'd1);
        check($sformatf("model_err i%0d a%0h", i, a), 32'(er), 32'(exp_err));
        if (known) check($sformatf("model_rdata i%0d a%0h", i, a), 32'(rd), 32'(exp_rd));
        if (we && !exp_err) mdl[i][idx] = int'(wd);
    endtask

    task automatic thru(input int i, input logic [7:0] a);
        int cyc;
        int times [$];
        @(negedge clk);
        vld_a[i]  = 1'b1;
        we_a[i]   = 1'b0;
        addr_a[i] = a;
        rrdy_a[i] = 1'b1;
        cyc = 0;
        while (times.size() < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rspv_a[i]) times.push_back(cyc);
        end
        vld_a[i] = 1'b0;
        check($sformatf("thru_count i%0d", i), 32'(times.size()), 32'd3);
        if (times.size() == 3) begin
            check($sformatf("thru_period1 i%0d", i), 32'(times[1] - times[0]), 32'(wc_of(i) + 2));
            check($sformatf("thru_period2 i%0d", i), 32'(times[2] - times[1]), 32'(wc_of(i) + 2));
        end
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int         inst;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t vt [$];

    task automatic add(input int inst, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input int hold, input logic [7:0] exp_rd, input bit exp_err);
        vec_t v;
        v.inst    = inst;
        v.we      = we;
        v.addr    = addr;
        v.wdata   = wdata;
        v.hold    = hold;
        v.exp_rd  = exp_rd;
        v.exp_err = exp_err;
        vt.push_back(v);
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        bit         seen;

        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 256; j++) mdl[i][j] = -1;
            addr_a[i] = 8'h00;
            wdat_a[i] = 8'h00;
        end
        rstn_a = '0;
        vld_a  = '0;
        we_a   = '0;
        rrdy_a = '1;

        add(0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, 1'b0);
        add(0, 1'b0, 8'h10, 8'h00, 0, 8'hA5, 1'b0);
        add(0, 1'b0, 8'h10, 8'h00, 5, 8'hA5, 1'b0);
        add(0, 1'b0, 8'h10, 8'h00, 0, 8'hA5, 1'b0);
        add(1, 1'b1, 8'h33, 8'h5A, 0, 8'h00, 1'b0);
        add(1, 1'b0, 8'h33, 8'h00, 0, 8'h5A, 1'b0);
        add(2, 1'b1, 8'h20, 8'h11, 0, 8'h00, 1'b0);
        add(2, 1'b0, 8'h20, 8'h00, 0, 8'h11, 1'b0);
        add(3, 1'b1, 8'h04, 8'h99, 0, 8'h00, 1'b0);
        add(3, 1'b1, 8'h14, 8'h3C, 0, 8'h00, ERR);
        add(3, 1'b0, 8'h04, 8'h00, 0, ERR ? 8'h99 : 8'h3C, 1'b0);
        add(3, 1'b0, 8'h14, 8'h00, 0, ERR ? 8'h00 : 8'h3C, ERR);
        add(0, 1'b1, 8'hFF, 8'hC3, 0, 8'h00, 1'b0);
        add(0, 1'b0, 8'hFF, 8'h00, 0, 8'hC3, 1'b0);
        add(3, 1'b1, 8'h0F, 8'hE1, 1, 8'h00, 1'b0);
        add(3, 1'b0, 8'h0F, 8'h00, 0, 8'hE1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("in_reset_req_ready i%0d", i), 32'(qrdy_a[i]), 32'd0);
            check($sformatf("in_reset_rsp_valid i%0d", i), 32'(rspv_a[i]), 32'd0);
        end
        rstn_a = '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_req_ready i%0d", i), 32'(qrdy_a[i]), 32'd1);
            check($sformatf("reset_rsp_valid i%0d", i), 32'(rspv_a[i]), 32'd0);
            check($sformatf("reset_rsp_rdata i%0d", i), 32'(rdat_a[i]), 32'h00);
            check($sformatf("reset_rsp_err i%0d", i), 32'(err_a[i]), 32'd0);
        end

        for (int k = 0; k < vt.size(); k++) begin
            do_txn(vt[k].inst, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].hold, rd, er);
            check($sformatf("tbl%0d rdata", k), 32'(rd), 32'(vt[k].exp_rd));
            check($sformatf("tbl%0d err", k), 32'(er), 32'(vt[k].exp_err));
        end

        thru(1, 8'h33);
        thru(2, 8'h20);
        thru(0, 8'h10);

        // Write aborted by reset two cycles after its accept, before its service point.
        @(negedge clk);
        vld_a[2]  = 1'b1;
        we_a[2]   = 1'b1;
        addr_a[2] = 8'h20;
        wdat_a[2] = 8'h77;
        wait_ready(2, "abort_accept_timeout");
        @(negedge clk);
        vld_a[2] = 1'b0;
        @(negedge clk);
        rstn_a[2] = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_in_reset_req_ready", 32'(qrdy_a[2]), 32'd0);
            if (rspv_a[2]) seen = 1'b1;
        end
        rstn_a[2] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rspv_a[2]) seen = 1'b1;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        do_txn(2, 1'b0, 8'h20, 8'h00, 0, rd, er);
        check("abort_write_not_done", 32'(rd), 32'h11);

        for (int k = 0; k < 80; k++) begin
            int         i;
            bit         we;
            logic [7:0] a;
            logic [7:0] wd;
            int         hold;
            i    = int'($urandom_range(0, NI - 1));
            we   = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 31));
            wd   = 8'($urandom_range(0, 255));
            hold = int'($urandom_range(0, 2));
            do_txn(i, we, a, wd, hold, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/risc8_mem_responder.md
# risc8_mem_responder

Responder end of the risc8 processor's memory bus. It accepts single read/write requests from the core over a valid/ready request channel. It services them against an internal byte-wide memory after a configurable number of wait states, and returns one response per request over a valid/ready response channel. It sits between the risc8 core and on-chip RAM and serves as the bus target for instruction and data accesses.

## Interface
- `DEPTH`, 256, number of 8-bit memory words; power of two, 2..256.
- `WAIT_CYCLES`, 1, wait states inserted between accept and response; 0..15.
- `clk` in 1 — single clock; all logic on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — core presents a request.
- `req_ready` out 1 — responder can accept a request.
- `req_we` in 1 — 1 = write, 0 = read.
- `req_addr` in 8 — byte address.
- `req_wdata` in 8 — write data.
- `rsp_valid` out 1 — response available.
- `rsp_ready` in 1 — core accepts response.
- `rsp_rdata` out 8 — read data; 8'h00 for writes.
- `rsp_err` out 1 — error flag; only meaningful with `RISC8_MEM_ERR_EN`.

## Operation
- Three-state FSM: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1, `rsp_valid`=0.
  - Accept occurs when `req_valid && req_ready`; latch `req_we`, `req_addr`, `req_wdata`.
  - If `WAIT_CYCLES`==0, go to RESP. Otherwise load wait counter with `WAIT_CYCLES-1` and go to WAIT.
- **WAIT**
  - `req_ready`=0; counter decrements each cycle.
  - At count 0, go to RESP.
- **Service point** (the cycle of entering RESP):
  - Write: `mem[idx]` <= latched wdata, and `rsp_rdata` <= 8'h00.
  - Read: `rsp_rdata` <= `mem[idx]`.
- **RESP**
  - `rsp_valid`=1, `req_ready`=0.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1, then the FSM returns to IDLE.
- Index rule without the error feature: idx = `req_addr` modulo `DEPTH` (low log2(DEPTH) bits).
- Memory array is not reset; contents are undefined until written.
- Exactly one outstanding transaction; no request pipelining.

## Timing
- **Reset values:** `req_ready`=0 while `reset_n`=0. After release, FSM=IDLE, so `req_ready`=1 from the first clock edge. Also `rsp_valid`=0, `rsp_rdata`=8'h00, `rsp_err`=0, wait counter=0.
- **Latency:** accept edge to `rsp_valid` high is `WAIT_CYCLES`+1 cycles.
- **Throughput:** with `rsp_ready` tied high, one transaction every `WAIT_CYCLES`+2 cycles. IDLE is always re-entered for at least one cycle before the next accept.
- **Backpressure:** `rsp_valid` stays high indefinitely while `rsp_ready`=0, with outputs unchanged.
- **Request channel:** `req_valid` during WAIT/RESP is ignored, not queued. The core must hold its request until it sees `req_ready`.
- **Reset mid-operation:** asserting `reset_n` low returns the FSM to IDLE and drops the pending transaction.
  - A write whose service point has not yet occurred is not performed.
  - A write already performed stays in memory.
- **Response handshake:** `rsp_ready` high in the same cycle `rsp_valid` first rises completes the response in that cycle, so `rsp_valid` is high for exactly one cycle.

## Configuration
- Macro: `RISC8_MEM_ERR_EN`.
- **Defined:**
  - Addresses >= `DEPTH` are errors. The FSM still follows the full IDLE/WAIT/RESP timing.
  - On error, write is suppressed, `rsp_rdata`=8'h00, `rsp_err`=1 in RESP.
  - `rsp_err`=0 for in-range accesses.
- **Undefined:**
  - `rsp_err` is a constant 0.
  - Addresses wrap modulo `DEPTH`.
  - No address comparison logic is built.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles, then release -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=8'h00, `rsp_err`=0.
- **Write then read, `WAIT_CYCLES`=1:** write 8'hA5 to 8'h10, then read 8'h10 -> each response `rsp_valid` rises 2 cycles after accept. Write `rsp_rdata`=8'h00; read `rsp_rdata`=8'hA5.
- **Backpressure:** read with `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_rdata` are held stable, `req_ready`=0, and a second `req_valid` is not accepted. Raise `rsp_ready` -> IDLE next cycle.
- **`WAIT_CYCLES`=0 and 4:** read latency is 1 and 5 cycles respectively; back-to-back throughput is 2 and 6 cycles per transaction.
- **Out of range, `DEPTH`=16:**
  - Macro on: write 8'h3C to 8'h14 -> `rsp_err`=1, and `mem[4]` is unchanged.
  - Macro off: same write -> `rsp_err`=0, and reading 8'h04 returns 8'h3C.
- **Reset mid-WAIT, `WAIT_CYCLES`=4:** write 8'h77 to 8'h20, then pull `reset_n` low 2 cycles after accept -> no response is produced. A subsequent read of 8'h20 returns the value written before the aborted write.
